// File: rtl/nvm_inference_sequencer.sv
// Purpose : Wishbone master that runs one inference pass over the 256-axon x 64-neuron
//           NVM core: per 16-neuron group, one synapse read per active axon, then the
//           group's picture-done write; finally reads back the 64-bit spike-out register.
// Latency : one SCAN cycle per axon per group plus one issue cycle and the slave wait per
//           bus transaction; done pulses one cycle after the final ack or the abort.
// Backpr. : each bus cycle holds until m_ack_i is sampled with stb high; after TIMEOUT
//           unacknowledged cycles the pass aborts and err is set.
//
// Ports:
//   wb_clk_i, wb_rst_i            clock, synchronous active-high reset
//   mask_we/mask_addr/mask_data   32-bit word writes into the 256-bit axon mask (ignored while busy)
//   stim_mag, start               stimulus magnitude sampled on the start pulse
//   busy, done, err, spikes       pass status and 64-bit spike result
//   m_*                           Wishbone classic single-beat master port
module nvm_inference_sequencer #(
  parameter logic [31:0] CORE_BASE = 32'h3000_0000,
  parameter logic [31:0] PD_BASE   = 32'h3000_2000,
  parameter logic [31:0] SO_BASE   = 32'h3000_1000,
  parameter logic [1:0]  READ_MODE = 2'b01,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        mask_we,
  input  logic [2:0]  mask_addr,
  input  logic [31:0] mask_data,
  input  logic [15:0] stim_mag,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [63:0] spikes,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  output logic        m_we_o,
  output logic [3:0]  m_sel_o,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  input  logic [31:0] m_dat_i,
  input  logic        m_ack_i
);

  // Counter only needs to reach TIMEOUT-1: the abort fires on the TIMEOUT-th waiting cycle.
  localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_RD, S_PD, S_SO0, S_SO1, S_FIN
  } state_t;

  state_t        r_state;
  logic [255:0]  r_mask;
  logic [1:0]    r_g;
  logic [7:0]    r_a;
  logic [15:0]   r_stim;
  logic [TW-1:0] r_tmo;
  logic          r_busy, r_done, r_err;
  logic          r_cyc, r_stb, r_we;
  logic [31:0]   r_adr, r_dat;
  logic [63:0]   r_spikes;

  logic          w_bus_st, w_we, w_ack, w_tmo;
  logic [31:0]   w_adr, w_dat;

  // Ack only counts while a strobe is outstanding; stray acks are ignored.
  assign w_ack = r_stb & m_ack_i;
  assign w_tmo = r_stb & ~m_ack_i & (r_tmo == TMO_LAST);

  // Transaction attributes for the bus states; latched into the output registers on issue.
  // {r_g, r_a} is exactly {row, col} with row = {g, a[7:5]} and col = a[4:0].
  always_comb begin
    w_bus_st = 1'b0;
    w_we     = 1'b0;
    w_adr    = '0;
    w_dat    = '0;
    case (r_state)
      S_RD: begin
        w_bus_st = 1'b1;
        w_adr    = CORE_BASE;
        w_dat    = {READ_MODE, r_g, r_a, 4'b0000, r_stim};
      end
      S_PD: begin
        w_bus_st = 1'b1;
        w_we     = 1'b1;
        w_adr    = PD_BASE + {29'd0, r_g, 1'b0};
      end
      S_SO0: begin
        w_bus_st = 1'b1;
        w_adr    = SO_BASE;
      end
      S_SO1: begin
        w_bus_st = 1'b1;
        w_adr    = SO_BASE + 32'd4;
      end
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state  <= S_IDLE;
      r_mask   <= '0;
      r_g      <= '0;
      r_a      <= '0;
      r_stim   <= '0;
      r_tmo    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_cyc    <= 1'b0;
      r_stb    <= 1'b0;
      r_we     <= 1'b0;
      r_adr    <= '0;
      r_dat    <= '0;
      r_spikes <= '0;
    end else begin
      r_done <= 1'b0;

      if (mask_we && !r_busy)
        r_mask[{mask_addr, 5'd0} +: 32] <= mask_data;

      // Bus cycle bookkeeping: issue one cycle after entering a bus state, end on ack or abort.
      if (r_stb) begin
        if (m_ack_i) begin
          r_cyc <= 1'b0;
          r_stb <= 1'b0;
        end else if (w_tmo) begin
          r_cyc   <= 1'b0;
          r_stb   <= 1'b0;
          r_err   <= 1'b1;
          r_state <= S_FIN;
        end else begin
          r_tmo <= r_tmo + 1'b1;
        end
      end else if (w_bus_st) begin
        r_cyc <= 1'b1;
        r_stb <= 1'b1;
        r_we  <= w_we;
        r_adr <= w_adr;
        r_dat <= w_dat;
        r_tmo <= '0;
      end

      case (r_state)
        S_IDLE: if (start) begin
          r_stim  <= stim_mag;
          r_err   <= 1'b0;
          r_g     <= '0;
          r_a     <= '0;
          r_busy  <= 1'b1;
          r_state <= S_SCAN;
        end
        S_SCAN: begin
          if (r_mask[r_a])        r_state <= S_RD;
          else if (r_a == 8'd255) r_state <= S_PD;
          else                    r_a <= r_a + 8'd1;
        end
        S_RD: if (w_ack) begin
          if (r_a == 8'd255) r_state <= S_PD;
          else begin
            r_a     <= r_a + 8'd1;
            r_state <= S_SCAN;
          end
        end
        S_PD: if (w_ack) begin
          if (r_g == 2'd3) r_state <= S_SO0;
          else begin
            r_g     <= r_g + 2'd1;
            r_a     <= '0;
            r_state <= S_SCAN;
          end
        end
        S_SO0: if (w_ack) begin
          r_spikes[31:0] <= m_dat_i;
          r_state        <= S_SO1;
        end
        S_SO1: if (w_ack) begin
          r_spikes[63:32] <= m_dat_i;
          r_state         <= S_FIN;
        end
        S_FIN: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign err     = r_err;
  assign spikes  = r_spikes;
  assign m_cyc_o = r_cyc;
  assign m_stb_o = r_stb;
  assign m_we_o  = r_we;
  assign m_sel_o = 4'hF;
  assign m_adr_o = r_adr;
  assign m_dat_o = r_dat;

endmodule

// File: tb/tb_nvm_inference_sequencer.sv
// Purpose : self-checking bench for nvm_inference_sequencer with a Wishbone slave model
//           and a transaction-list reference model derived from the pass rules.
// Latency : n/a (bench).
// Backpr. : slave ack latency, stray acks and a never-ack read are all configurable.
module tb_nvm_inference_sequencer;

  localparam logic [31:0] CORE_BASE = 32'h3000_0000;
  localparam logic [31:0] PD_BASE   = 32'h3000_2000;
  localparam logic [31:0] SO_BASE   = 32'h3000_1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mask_we = 1'b0;
  logic [2:0]  mask_addr = '0;
  logic [31:0] mask_data = '0;
  logic [15:0] stim_mag = '0;
  logic        start = 1'b0;
  logic        m_busy, m_done, m_err;
  logic [63:0] m_spikes;
  logic        m_cyc_o, m_stb_o, m_we_o;
  logic [3:0]  m_sel_o;
  logic [31:0] m_adr_o, m_dat_o;
  logic [31:0] m_dat_i = '0;
  logic        m_ack_i = 1'b0;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } txn_t;

  txn_t got_q[$];
  txn_t exp_q[$];

  // slave model state
  int          ack_lat = 0;
  int          no_ack_nth = 0;
  int          rd_issued = 0;
  bit          stray_en = 1'b0;
  int          stb_cycles = 0;
  int          last_stb_cycles = 0;
  bit          stb_prev = 1'b0;
  bit          acked_last = 1'b0;
  bit          suppress = 1'b0;
  txn_t        rise_t;
  logic [31:0] so_lo = '0;
  logic [31:0] so_hi = '0;
  int          proto_err = 0;
  int          done_cnt = 0;
  logic [63:0] last_exp_spikes = '0;

  nvm_inference_sequencer dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .mask_we  (mask_we),
    .mask_addr(mask_addr),
    .mask_data(mask_data),
    .stim_mag (stim_mag),
    .start    (start),
    .busy     (m_busy),
    .done     (m_done),
    .err      (m_err),
    .spikes   (m_spikes),
    .m_cyc_o  (m_cyc_o),
    .m_stb_o  (m_stb_o),
    .m_we_o   (m_we_o),
    .m_sel_o  (m_sel_o),
    .m_adr_o  (m_adr_o),
    .m_dat_o  (m_dat_o),
    .m_dat_i  (m_dat_i),
    .m_ack_i  (m_ack_i)
  );

  always #5 clk = ~clk;

  // Wishbone slave + protocol monitor, evaluated mid-cycle.
  always @(negedge clk) begin
    if (m_stb_o) begin
      if (!stb_prev) begin
        rise_t     = {m_we_o, m_adr_o, m_dat_o};
        stb_cycles = 0;
        if (!m_we_o && m_adr_o == CORE_BASE) rd_issued++;
        suppress = (no_ack_nth != 0) && !m_we_o && (m_adr_o == CORE_BASE) && (rd_issued == no_ack_nth);
      end
      if (acked_last) proto_err++;
      if ({m_we_o, m_adr_o, m_dat_o} != rise_t || !m_cyc_o || m_sel_o != 4'hF) proto_err++;
      stb_cycles++;
      if (!suppress && stb_cycles > ack_lat) begin
        m_ack_i = 1'b1;
        if (m_adr_o == SO_BASE)              m_dat_i = so_lo;
        else if (m_adr_o == SO_BASE + 32'd4) m_dat_i = so_hi;
        else                                 m_dat_i = $urandom;
        got_q.push_back(rise_t);
        acked_last = 1'b1;
      end else begin
        m_ack_i    = 1'b0;
        acked_last = 1'b0;
      end
    end else begin
      if (stb_prev) last_stb_cycles = stb_cycles;
      if (m_cyc_o) proto_err++;
      acked_last = 1'b0;
      m_ack_i    = stray_en && ($urandom_range(0, 3) == 0);
      m_dat_i    = $urandom;
    end
    if (m_done) done_cnt++;
    stb_prev = m_stb_o;
  end

  // Reference model: the full ordered transaction list of a successful pass.
  task automatic build_expected(input logic [255:0] m, input logic [15:0] s);
    txn_t t;
    logic [31:0] row, col;
    exp_q.delete();
    for (int g = 0; g < 4; g++) begin
      for (int a = 0; a < 256; a++) begin
        if (m[a]) begin
          row   = 32'(g * 8 + a / 32);
          col   = 32'(a % 32);
          t.we  = 1'b0;
          t.adr = CORE_BASE;
          t.dat = 32'h4000_0000 + row * 32'h0200_0000 + col * 32'h0010_0000 + {16'd0, s};
          exp_q.push_back(t);
        end
      end
      t.we  = 1'b1;
      t.adr = PD_BASE + 32'(2 * g);
      t.dat = 32'd0;
      exp_q.push_back(t);
    end
    t.we = 1'b0; t.adr = SO_BASE;         t.dat = 32'd0; exp_q.push_back(t);
    t.we = 1'b0; t.adr = SO_BASE + 32'd4; t.dat = 32'd0; exp_q.push_back(t);
  endtask

  // Index of first differing transaction, or -1 when the observed list matches the model.
  function automatic int first_diff();
    int n;
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (got_q[i].we !== exp_q[i].we || got_q[i].adr !== exp_q[i].adr) return i;
      if ((exp_q[i].we || exp_q[i].adr == CORE_BASE) && got_q[i].dat !== exp_q[i].dat) return i;
    end
    if (got_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  task automatic load_mask(input logic [255:0] m);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      mask_we   = 1'b1;
      mask_addr = 3'(k);
      mask_data = m[k*32 +: 32];
    end
    @(negedge clk);
    mask_we = 1'b0;
  endtask

  task automatic do_start(input logic [15:0] s);
    got_q.delete();
    rd_issued = 0;
    done_cnt  = 0;
    @(negedge clk);
    stim_mag = s;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output bit ok);
    cyc = 1;
    while (!m_done && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    ok = m_done;
    repeat (6) @(negedge clk);
  endtask

  function automatic logic [255:0] rand_mask(input int dens);
    logic [255:0] m;
    for (int b = 0; b < 256; b++) m[b] = ($urandom_range(0, 99) < dens);
    return m;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (m_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", m_busy); end
    total++; if (m_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", m_done); end
    total++; if (m_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", m_err); end
    total++; if (m_spikes !== 64'd0) begin bad++; $display("FAIL reset_spikes got=%h want=0", m_spikes); end
    total++; if ({m_cyc_o, m_stb_o, m_we_o} !== 3'b000) begin bad++; $display("FAIL reset_ctl got=%b want=000", {m_cyc_o, m_stb_o, m_we_o}); end
    total++; if (m_adr_o !== 32'd0 || m_dat_o !== 32'd0) begin bad++; $display("FAIL reset_adr_dat got=%h/%h want=0/0", m_adr_o, m_dat_o); end
    total++; if (m_sel_o !== 4'hF) begin bad++; $display("FAIL reset_sel got=%h want=f", m_sel_o); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_axon();
    logic [255:0] m;
    int cyc; bit ok; int d;
    m = '0; m[37] = 1'b1;
    so_lo = 32'hA5A5_0001; so_hi = 32'h0000_8000; ack_lat = 0; stray_en = 1'b0;
    load_mask(m);
    do_start(16'h0005);
    total++; if (m_busy !== 1'b1) begin bad++; $display("FAIL single_busy_rise got=%b want=1", m_busy); end
    wait_done(cyc, ok);
    total++; if (!ok) begin bad++; $display("FAIL single_done_wait got=timeout want=done"); end
    build_expected(m, 16'h0005);
    d = first_diff();
    total++; if (d != -1) begin bad++; $display("FAIL single_seq diff_at=%0d got_n=%0d want_n=%0d", d, got_q.size(), exp_q.size()); end
    total++; if (m_spikes !== 64'h0000_8000_A5A5_0001) begin bad++; $display("FAIL single_spikes got=%h want=0000_8000_a5a5_0001", m_spikes); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL single_done_cnt got=%0d want=1", done_cnt); end
    total++; if (m_err !== 1'b0 || m_busy !== 1'b0) begin bad++; $display("FAIL single_status got err=%b busy=%b want 0/0", m_err, m_busy); end
    last_exp_spikes = {so_hi, so_lo};
  endtask

  task automatic test_random();
    logic [255:0] m;
    logic [15:0] s;
    int cyc; bit ok; int d;
    stray_en = 1'b1;
    for (int it = 0; it < 3; it++) begin
      m = rand_mask($urandom_range(2, 30));
      s = 16'($urandom);
      so_lo = $urandom; so_hi = $urandom;
      ack_lat = $urandom_range(0, 3);
      load_mask(m);
      do_start(s);
      wait_done(cyc, ok);
      build_expected(m, s);
      d = first_diff();
      total++; if (!ok || d != -1) begin bad++; $display("FAIL random_seq it=%0d done=%b diff_at=%0d got_n=%0d want_n=%0d", it, ok, d, got_q.size(), exp_q.size()); end
      total++; if (m_spikes !== {so_hi, so_lo} || done_cnt != 1) begin bad++; $display("FAIL random_result it=%0d got=%h/%0d want=%h/1", it, m_spikes, done_cnt, {so_hi, so_lo}); end
      last_exp_spikes = {so_hi, so_lo};
    end
    stray_en = 1'b0;
  endtask

  task automatic test_empty();
    int cyc; bit ok; int d;
    so_lo = $urandom; so_hi = $urandom; ack_lat = 0;
    load_mask('0);
    do_start(16'h1234);
    wait_done(cyc, ok);
    build_expected('0, 16'h1234);
    d = first_diff();
    total++; if (!ok || d != -1 || got_q.size() != 6) begin bad++; $display("FAIL empty_seq done=%b diff_at=%0d got_n=%0d want_n=6", ok, d, got_q.size()); end
    total++; if (cyc < 1024) begin bad++; $display("FAIL empty_len got=%0d want>=1024", cyc); end
    total++; if (m_spikes !== {so_hi, so_lo}) begin bad++; $display("FAIL empty_spikes got=%h want=%h", m_spikes, {so_hi, so_lo}); end
    last_exp_spikes = {so_hi, so_lo};
  endtask

  task automatic test_full_mask();
    int cyc; bit ok; int d; int nrd;
    so_lo = $urandom; so_hi = $urandom; ack_lat = 0;
    load_mask('1);
    do_start(16'hBEEF);
    wait_done(cyc, ok);
    build_expected('1, 16'hBEEF);
    d = first_diff();
    nrd = 0;
    foreach (got_q[i]) if (!got_q[i].we && got_q[i].adr == CORE_BASE) nrd++;
    total++; if (!ok || d != -1) begin bad++; $display("FAIL full_seq done=%b diff_at=%0d got_n=%0d want_n=%0d", ok, d, got_q.size(), exp_q.size()); end
    total++; if (nrd != 1024) begin bad++; $display("FAIL full_reads got=%0d want=1024", nrd); end
    total++; if (m_err !== 1'b0) begin bad++; $display("FAIL full_err got=%b want=0", m_err); end
    last_exp_spikes = {so_hi, so_lo};
  endtask

  task automatic test_timeout();
    logic [255:0] m;
    int cyc; bit ok; int d;
    m = rand_mask(10);
    m[3] = 1'b1; m[100] = 1'b1; m[200] = 1'b1;
    so_lo = $urandom; so_hi = $urandom; ack_lat = 1; no_ack_nth = 3;
    load_mask(m);
    do_start(16'h0777);
    wait_done(cyc, ok);
    build_expected(m, 16'h0777);
    while (exp_q.size() > 2) void'(exp_q.pop_back());
    d = first_diff();
    total++; if (!ok || d != -1) begin bad++; $display("FAIL timeout_seq done=%b diff_at=%0d got_n=%0d want_n=2", ok, d, got_q.size()); end
    total++; if (last_stb_cycles != 255) begin bad++; $display("FAIL timeout_wait got=%0d want=255", last_stb_cycles); end
    total++; if (m_err !== 1'b1) begin bad++; $display("FAIL timeout_err got=%b want=1", m_err); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL timeout_done_cnt got=%0d want=1", done_cnt); end
    total++; if (m_spikes !== last_exp_spikes) begin bad++; $display("FAIL timeout_spikes got=%h want=%h", m_spikes, last_exp_spikes); end
    no_ack_nth = 0;
  endtask

  task automatic test_busy_ignore();
    logic [255:0] m;
    logic [15:0] s;
    int cyc; bit ok; int d;
    m = rand_mask(8); m[5] = 1'b1;
    s = 16'($urandom);
    so_lo = $urandom; so_hi = $urandom; ack_lat = 0;
    load_mask(m);
    do_start(s);
    repeat (3) @(negedge clk);
    total++; if (m_busy !== 1'b1 || m_err !== 1'b0) begin bad++; $display("FAIL busy_status got busy=%b err=%b want 1/0", m_busy, m_err); end
    load_mask(~m);
    @(negedge clk);
    stim_mag = ~s;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc, ok);
    repeat (20) @(negedge clk);
    build_expected(m, s);
    d = first_diff();
    total++; if (!ok || d != -1) begin bad++; $display("FAIL busy_seq done=%b diff_at=%0d got_n=%0d want_n=%0d", ok, d, got_q.size(), exp_q.size()); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL busy_done_cnt got=%0d want=1", done_cnt); end
    last_exp_spikes = {so_hi, so_lo};
  endtask

  task automatic test_reset_mid();
    logic [255:0] m;
    logic [15:0] s;
    int cyc; bit ok; int d; int w;
    m = rand_mask(5); m[10] = 1'b1;
    ack_lat = 6;
    load_mask(m);
    do_start(16'h00AA);
    w = 0;
    while (!(m_stb_o && !m_we_o) && w < 3000) begin
      @(negedge clk);
      w++;
    end
    total++; if (!(m_stb_o && !m_we_o)) begin bad++; $display("FAIL rstmid_reach_rd got=no_read want=read"); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    total++; if (m_cyc_o !== 1'b0 || m_stb_o !== 1'b0 || m_busy !== 1'b0) begin bad++; $display("FAIL rstmid_drop got cyc=%b stb=%b busy=%b want 0/0/0", m_cyc_o, m_stb_o, m_busy); end
    total++; if (m_spikes !== 64'd0 || m_err !== 1'b0) begin bad++; $display("FAIL rstmid_outputs got spikes=%h err=%b want 0/0", m_spikes, m_err); end
    @(negedge clk);
    rst = 1'b0;
    m = rand_mask(6);
    s = 16'($urandom);
    so_lo = $urandom; so_hi = $urandom; ack_lat = 2;
    load_mask(m);
    do_start(s);
    wait_done(cyc, ok);
    build_expected(m, s);
    d = first_diff();
    total++; if (!ok || d != -1) begin bad++; $display("FAIL rstmid_clean_seq done=%b diff_at=%0d got_n=%0d want_n=%0d", ok, d, got_q.size(), exp_q.size()); end
    total++; if (m_spikes !== {so_hi, so_lo} || m_err !== 1'b0) begin bad++; $display("FAIL rstmid_clean_result got=%h err=%b want=%h err=0", m_spikes, m_err, {so_hi, so_lo}); end
  endtask

  initial begin
    test_reset();
    test_single_axon();
    test_random();
    test_empty();
    test_full_mask();
    test_timeout();
    test_busy_ignore();
    test_reset_mid();
    total++; if (proto_err != 0) begin bad++; $display("FAIL bus_protocol got=%0d violations want=0", proto_err); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
